// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one AES block through LOAD, per-round key fetch and round execution.
// Optional feature macro: AES_DECRYPT_EN (when defined, dir=1 walks round keys nr down to 0).
// Ports:
//   i_clk        clock, all state changes on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      start one block operation (sampled in IDLE only)
//   i_nk         key length in 32-bit words (4, 6 or 8), sampled with start
//   i_dir        0 encrypt, 1 decrypt (ignored without AES_DECRYPT_EN)
//   i_abort      cancel the operation in progress
//   i_rk_ready   round key o_rk_idx is valid
//   o_rk_req     round key request (WAIT_KEY)
//   o_rk_idx     index of the round key requested / in use
//   o_ld_in      one-cycle strobe: load input block
//   o_rnd_en     one-cycle strobe: commit current round
//   o_rnd_type   00 initial AddRoundKey, 01 full round, 10 final round
//   o_busy       high from LOAD through EXEC
//   o_done       one-cycle pulse at block completion
//   o_err        one-cycle pulse after start with illegal nk
module aes_round_ctrl #(
    parameter int ROUND_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_nk,
    input  logic       i_dir,
    input  logic       i_abort,
    input  logic       i_rk_ready,
    output logic       o_rk_req,
    output logic [3:0] o_rk_idx,
    output logic       o_ld_in,
    output logic       o_rnd_en,
    output logic [1:0] o_rnd_type,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_KEY, S_EXEC, S_DONE} state_t;
    state_t     r_state, w_state_nxt;
    logic [3:0] r_rnd, w_rnd_nxt, r_nr, w_idx;
    logic [2:0] r_cyc, w_cyc_nxt;
    logic       r_err, w_nk_ok, w_go, w_last, w_clr;
    assign w_nk_ok = (i_nk == 4'd4) || (i_nk == 4'd6) || (i_nk == 4'd8);
    assign w_go    = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_last  = (r_state == S_EXEC) && (r_cyc == 3'(ROUND_CYCLES - 1));
    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        w_cyc_nxt   = '0;
        case (r_state)
            S_IDLE:     w_state_nxt = (w_go && w_nk_ok) ? S_LOAD : S_IDLE;
            S_LOAD: begin
                w_state_nxt = S_WAIT_KEY;
                w_rnd_nxt   = '0;
            end
            S_WAIT_KEY: w_state_nxt = i_rk_ready ? S_EXEC : S_WAIT_KEY;
            S_EXEC: begin
                if (!w_last) w_cyc_nxt = r_cyc + 3'd1;
                else if (r_rnd == r_nr) w_state_nxt = S_DONE;
                else begin
                    w_state_nxt = S_WAIT_KEY;
                    w_rnd_nxt   = r_rnd + 4'd1;
                end
            end
            default:    w_state_nxt = S_IDLE;
        endcase
        // abort overrides every transition, including the final-round exit
        if (i_abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_rnd_nxt   = '0;
            w_cyc_nxt   = '0;
        end
    end
`ifdef AES_DECRYPT_EN
    logic r_dir;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_dir <= 1'b0;
        else if (w_go && w_nk_ok) r_dir <= i_dir;
    end
    assign w_idx = r_dir ? r_nr - w_rnd_nxt : w_rnd_nxt;
`else
    logic w_unused_dir;
    assign w_unused_dir = i_dir;
    assign w_idx = w_rnd_nxt;
`endif
    // key index / round type are held at zero outside an operation so the
    // previous block's values never leak into IDLE or LOAD
    assign w_clr = (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_rnd      <= '0;
            r_cyc      <= '0;
            r_nr       <= 4'd10;
            r_err      <= 1'b0;
            o_rk_idx   <= '0;
            o_rnd_type <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_rnd      <= w_rnd_nxt;
            r_cyc      <= w_cyc_nxt;
            r_err      <= w_go && !w_nk_ok;
            if (w_go && w_nk_ok) r_nr <= i_nk + 4'd6;
            o_rk_idx   <= w_clr ? 4'd0 : w_idx;
            o_rnd_type <= (w_clr || w_rnd_nxt == 4'd0) ? 2'b00 : (w_rnd_nxt == r_nr) ? 2'b10 : 2'b01;
        end
    end
    assign o_rk_req = (r_state == S_WAIT_KEY);
    assign o_ld_in  = (r_state == S_LOAD) && !i_abort;
    assign o_rnd_en = w_last && !i_abort;
    assign o_done   = (r_state == S_DONE) && !i_abort;
    assign o_busy   = (r_state == S_LOAD) || (r_state == S_WAIT_KEY) || (r_state == S_EXEC);
    assign o_err    = r_err;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl with ROUND_CYCLES=1 and ROUND_CYCLES=3 instances.
module tb_aes_round_ctrl;
    logic       clk = 0, rst_n = 0, start_a = 0, start_b = 0, dir = 0, abort = 0, rk_ready = 0, sel = 0;
    logic [3:0] nk = 4'd4;
    logic       a_rk_req, a_ld_in, a_rnd_en, a_busy, a_done, a_err;
    logic       b_rk_req, b_ld_in, b_rnd_en, b_busy, b_done, b_err;
    logic [3:0] a_rk_idx, b_rk_idx;
    logic [1:0] a_rnd_type, b_rnd_type;
    logic       s_rk_req, s_ld_in, s_rnd_en, s_busy, s_done, s_err;
    logic [3:0] s_rk_idx;
    logic [1:0] s_rnd_type;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.ROUND_CYCLES(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_nk(nk), .i_dir(dir), .i_abort(abort),
        .i_rk_ready(rk_ready), .o_rk_req(a_rk_req), .o_rk_idx(a_rk_idx), .o_ld_in(a_ld_in),
        .o_rnd_en(a_rnd_en), .o_rnd_type(a_rnd_type), .o_busy(a_busy), .o_done(a_done), .o_err(a_err));
    aes_round_ctrl #(.ROUND_CYCLES(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_nk(nk), .i_dir(dir), .i_abort(abort),
        .i_rk_ready(rk_ready), .o_rk_req(b_rk_req), .o_rk_idx(b_rk_idx), .o_ld_in(b_ld_in),
        .o_rnd_en(b_rnd_en), .o_rnd_type(b_rnd_type), .o_busy(b_busy), .o_done(b_done), .o_err(b_err));

    assign s_rk_req   = sel ? b_rk_req   : a_rk_req;
    assign s_ld_in    = sel ? b_ld_in    : a_ld_in;
    assign s_rnd_en   = sel ? b_rnd_en   : a_rnd_en;
    assign s_busy     = sel ? b_busy     : a_busy;
    assign s_done     = sel ? b_done     : a_done;
    assign s_err      = sel ? b_err      : a_err;
    assign s_rk_idx   = sel ? b_rk_idx   : a_rk_idx;
    assign s_rnd_type = sel ? b_rnd_type : a_rnd_type;

    // one full operation; checks every round strobe, key request cycles and completion cycle
    task automatic run_check(input string name, input logic use_b, input logic [3:0] knk, input logic kdir,
                             input int stall, input logic noise, input int exp_done);
        int cyc, n, w, done_cyc, ld_cyc, req_cycles, bad_busy, nr, rc, exp_cyc;
        logic [3:0] exp_idx;
        logic [1:0] exp_type;
        nr = int'(knk) + 6;
        rc = use_b ? 3 : 1;
        n = 0; w = 0; done_cyc = -1; ld_cyc = -1; req_cycles = 0; bad_busy = 0;
        sel = use_b;
        @(negedge clk);
        nk = knk; dir = kdir; rk_ready = (stall == 0);
        if (use_b) start_b = 1; else start_a = 1;
        @(posedge clk);
        #1 start_a = 0; start_b = 0;
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (noise && cyc >= 3) begin
                if (use_b) start_b = 1; else start_a = 1;
                nk = 4'd8; dir = ~kdir;
            end
            if (s_ld_in) ld_cyc = cyc;
            if (s_rk_req) begin
                req_cycles++;
                if (w < stall) begin rk_ready = 0; w++; end
                else begin rk_ready = 1; w = 0; end
            end
            if (s_rnd_en) begin
`ifdef AES_DECRYPT_EN
                exp_idx = kdir ? 4'(nr - n) : 4'(n);
`else
                exp_idx = 4'(n);
`endif
                exp_type = (n == 0) ? 2'b00 : (n == nr) ? 2'b10 : 2'b01;
                exp_cyc = 2 + stall + rc + n * (stall + 1 + rc);
                total++;
                if (s_rk_idx !== exp_idx || s_rnd_type !== exp_type || cyc != exp_cyc) begin
                    bad++;
                    $display("FAIL %s round %0d: idx=%0d type=%0d cyc=%0d, want idx=%0d type=%0d cyc=%0d",
                             name, n, s_rk_idx, s_rnd_type, cyc, exp_idx, exp_type, exp_cyc);
                end
                n++;
            end
            if (s_done) begin
                done_cyc = cyc;
                start_a = 0; start_b = 0;
                break;
            end
            if (!s_busy) bad_busy++;
        end
        start_a = 0; start_b = 0;
        total++;
        if (ld_cyc != 1) begin bad++; $display("FAIL %s ld_in cycle: got %0d want 1", name, ld_cyc); end
        total++;
        if (n != nr + 1) begin bad++; $display("FAIL %s rnd_en count: got %0d want %0d", name, n, nr + 1); end
        total++;
        if (done_cyc != exp_done) begin bad++; $display("FAIL %s done cycle: got %0d want %0d", name, done_cyc, exp_done); end
        total++;
        if (req_cycles != (nr + 1) * (stall + 1)) begin
            bad++; $display("FAIL %s rk_req cycles: got %0d want %0d", name, req_cycles, (nr + 1) * (stall + 1));
        end
        total++;
        if (bad_busy != 0 || s_busy !== 1'b0) begin
            bad++; $display("FAIL %s busy: idle-cycles=%0d busy@done=%b want 0/0", name, bad_busy, s_busy);
        end
        @(negedge clk);
        total++;
        if ({s_busy, s_done, s_rk_idx, s_rnd_type} !== 8'h00) begin
            bad++; $display("FAIL %s idle after done: busy=%b done=%b idx=%0d type=%0d", name, s_busy, s_done, s_rk_idx, s_rnd_type);
        end
        nk = 4'd4; dir = 0; rk_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; sel = 0;
        #12;
        total++;
        if ({a_rk_req, a_ld_in, a_rnd_en, a_busy, a_done, a_err, a_rk_idx, a_rnd_type} !== 12'h000) begin
            bad++; $display("FAIL reset_hold: outputs=%h want 000", {a_rk_req, a_ld_in, a_rnd_en, a_busy, a_done, a_err, a_rk_idx, a_rnd_type});
        end
        @(negedge clk); rst_n = 1;
        repeat (3) @(negedge clk);
        total++;
        if ({a_rk_req, a_ld_in, a_rnd_en, a_busy, a_done, a_err, a_rk_idx, a_rnd_type,
             b_busy, b_done, b_err} !== 15'h0000) begin
            bad++; $display("FAIL reset_release: outputs not at reset values");
        end
    endtask

    task automatic test_encrypt;
        run_check("enc_nk4", 1'b0, 4'd4, 1'b0, 0, 1'b0, 24);
    endtask

    task automatic test_stall;
        run_check("stall_nk8", 1'b0, 4'd8, 1'b0, 3, 1'b0, 77);
    endtask

    task automatic test_err;
        logic [3:0] bad_nk [3] = '{4'd5, 4'd0, 4'd15};
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); nk = bad_nk[i]; start_a = 1;
            @(posedge clk); #1 start_a = 0;
            @(negedge clk);
            total++;
            if ({a_err, a_busy, a_ld_in} !== 3'b100) begin
                bad++; $display("FAIL err nk=%0d cycle1: err/busy/ld=%b want 100", bad_nk[i], {a_err, a_busy, a_ld_in});
            end
            @(negedge clk);
            total++;
            if ({a_err, a_busy, a_ld_in} !== 3'b000) begin
                bad++; $display("FAIL err nk=%0d cycle2: err/busy/ld=%b want 000", bad_nk[i], {a_err, a_busy, a_ld_in});
            end
        end
        nk = 4'd4;
    endtask

    task automatic test_abort;
        int strobes;
        sel = 0;
        @(negedge clk); nk = 4'd6; start_a = 1; rk_ready = 1;
        @(posedge clk); #1 start_a = 0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        total++;
        if (a_rk_req !== 1'b1 || a_rk_idx !== 4'd5) begin
            bad++; $display("FAIL abort_pre: rk_req=%b idx=%0d want 1/5", a_rk_req, a_rk_idx);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
        total++;
        if ({a_busy, a_rk_req, a_rk_idx, a_rnd_type} !== 8'h00) begin
            bad++; $display("FAIL abort_idle: busy=%b req=%b idx=%0d type=%0d want 0", a_busy, a_rk_req, a_rk_idx, a_rnd_type);
        end
        strobes = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_rnd_en || a_done || a_ld_in || a_busy) strobes++;
        end
        total++;
        if (strobes != 0) begin bad++; $display("FAIL abort_quiet: activity cycles=%0d want 0", strobes); end
        @(negedge clk); nk = 4'd4; start_a = 1; abort = 1;
        @(posedge clk); #1 start_a = 0; abort = 0;
        @(negedge clk);
        total++;
        if ({a_busy, a_ld_in, a_err} !== 3'b000) begin
            bad++; $display("FAIL abort_idle_start: busy/ld/err=%b want 000", {a_busy, a_ld_in, a_err});
        end
        rk_ready = 0;
        run_check("after_abort", 1'b0, 4'd4, 1'b0, 0, 1'b0, 24);
    endtask

    task automatic test_back_to_back;
        run_check("noise_nk6", 1'b0, 4'd6, 1'b0, 0, 1'b1, 28);
        run_check("b2b_nk4", 1'b0, 4'd4, 1'b0, 0, 1'b0, 24);
    endtask

    task automatic test_round_cycles;
        run_check("rc3_nk6_dir1", 1'b1, 4'd6, 1'b1, 0, 1'b0, 54);
        run_check("rc3_nk4_stall2", 1'b1, 4'd4, 1'b0, 2, 1'b0, 68);
    endtask

    task automatic test_reset_mid;
        int act;
        sel = 0;
        @(negedge clk); nk = 4'd4; start_a = 1; rk_ready = 1;
        @(posedge clk); #1 start_a = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++;
        if (a_rnd_en !== 1'b1 || a_rk_idx !== 4'd2) begin
            bad++; $display("FAIL rst_mid_pre: rnd_en=%b idx=%0d want 1/2", a_rnd_en, a_rk_idx);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if ({a_rk_req, a_ld_in, a_rnd_en, a_busy, a_done, a_err, a_rk_idx, a_rnd_type} !== 12'h000) begin
            bad++; $display("FAIL rst_mid_async: outputs=%h want 000", {a_rk_req, a_ld_in, a_rnd_en, a_busy, a_done, a_err, a_rk_idx, a_rnd_type});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        act = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_done || a_busy || a_rnd_en) act++;
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL rst_mid_after: activity cycles=%0d want 0", act); end
        rk_ready = 0;
        run_check("after_reset", 1'b0, 4'd4, 1'b0, 0, 1'b0, 24);
    endtask

    initial begin
        test_reset;
        test_encrypt;
        test_stall;
        test_err;
        test_abort;
        test_back_to_back;
        test_round_cycles;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
